// File: rtl/post_spike_tx.sv
// Time-multiplexed LIF sweep engine for the output neurons: integrates, leaks,
// inhibits and fires one neuron per cycle, streaming indexed spike beats to the post buffer.
module post_spike_tx #(
  parameter int          N_NRN      = 18,
  parameter logic [15:0] THRESH     = 16'd4096,
  parameter int          LEAK_SHIFT = 4,
  parameter logic [2:0]  REFRAC     = 3'd2,
  parameter logic [15:0] INHBT_W    = 16'd64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_cnt_clr,
  input  logic                  i_s_init,
  input  logic [16*N_NRN-1:0]   i_cur,
  input  logic [4:0]            i_inhbt,
  output logic                  o_valid,
  output logic                  o_spike,
  output logic [4:0]            o_neuron_idx,
  output logic                  o_s_init,
  output logic                  o_cnt_clr,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, INIT, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_NRN - 1);

  state_t state, state_nxt;

  logic [4:0]          idx;
  logic [16*N_NRN-1:0] cur_q;
  logic [4:0]          inhbt_q;
  logic [15:0]         vmem   [N_NRN];
  logic [2:0]          refrac [N_NRN];

  logic        last;
  logic        accept_start;
  logic [15:0] vm;
  logic [15:0] leak;
  logic [15:0] cur_k;
  logic [2:0]  refrac_k;
  logic [19:0] inhbt_term;
  logic signed [19:0] s_raw;
  logic [15:0] s_clamp;
  logic        fire;
  logic [15:0] vmem_nxt;
  logic [2:0]  refrac_nxt;

  assign last         = (idx == LAST_IDX);
  assign accept_start = (state == IDLE) && !i_s_init && i_start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // i_s_init outranks a same-cycle i_start; both are ignored once busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_s_init)     state_nxt = INIT;
        else if (i_start) state_nxt = SWEEP;
      end
      SWEEP:   if (last) state_nxt = DONE;
      INIT:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (state == SWEEP || state == INIT) begin
      idx <= last ? 5'd0 : idx + 5'd1;
    end else begin
      idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q   <= '0;
      inhbt_q <= '0;
    end else if (accept_start) begin
      cur_q   <= i_cur;
      inhbt_q <= i_inhbt;
    end
  end

  // Membrane update for neuron idx; 20-bit signed covers both clamp directions.
  always_comb begin
    vm         = vmem[idx];
    refrac_k   = refrac[idx];
    leak       = vm >> LEAK_SHIFT;
    cur_k      = cur_q[16*idx +: 16];
    inhbt_term = {15'd0, inhbt_q} * {4'd0, INHBT_W};
    s_raw      = $signed({4'd0, vm}) - $signed({4'd0, leak})
               + $signed({4'd0, cur_k}) - $signed(inhbt_term);
    if (s_raw[19])                s_clamp = 16'd0;
    else if (s_raw > 20'sd65535)  s_clamp = 16'hFFFF;
    else                          s_clamp = s_raw[15:0];

    fire       = 1'b0;
    vmem_nxt   = s_clamp;
    refrac_nxt = refrac_k;
    if (refrac_k != 3'd0) begin
      vmem_nxt   = 16'd0;
      refrac_nxt = refrac_k - 3'd1;
    end else if (s_clamp >= THRESH) begin
      fire       = 1'b1;
      vmem_nxt   = 16'd0;
      refrac_nxt = REFRAC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_NRN; k++) begin
        vmem[k]   <= '0;
        refrac[k] <= '0;
      end
    end else if (state == SWEEP) begin
      vmem[idx]   <= vmem_nxt;
      refrac[idx] <= refrac_nxt;
    end else if (state == INIT) begin
      vmem[idx]   <= '0;
      refrac[idx] <= '0;
    end
  end

  // Beats lag processing by one cycle; busy tracks the registered state ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid      <= 1'b0;
      o_spike      <= 1'b0;
      o_neuron_idx <= '0;
      o_s_init     <= 1'b0;
      o_cnt_clr    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_valid      <= (state == SWEEP);
      o_spike      <= (state == SWEEP) && fire;
      o_neuron_idx <= (state == SWEEP || state == INIT) ? idx : 5'd0;
      o_s_init     <= (state == INIT);
      o_cnt_clr    <= accept_start && i_cnt_clr;
      o_busy       <= (state_nxt != IDLE);
      o_done       <= (state == DONE);
    end
  end

endmodule

// File: doc/post_spike_tx.md
Name: post_spike_tx

Overview:
- Time-multiplexed LIF neuron sweep engine for the 18 output neurons.
- On each timestep start it integrates per-neuron input current with leak and lateral inhibition, and fires on threshold.
- It serially transmits the result as the neuron-indexed spike stream (valid/spike/idx/s_init/cnt_clr) that the post-synaptic buffer consumes.
- It is the transmitting end of that per-neuron spike interface; it sits between the synaptic current accumulator and the post buffer.

Parameters:
- N_NRN, 18, neurons per sweep (index width fixed at 5 bits).
- THRESH, 16'd4096, firing threshold (unsigned).
- LEAK_SHIFT, 4, leak = vmem >> LEAK_SHIFT per sweep.
- REFRAC, 2, refractory sweeps after a spike (0..7).
- INHBT_W, 16'd64, membrane decrement per inhibit count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  timestep start pulse; accepted only in IDLE.
- i_cnt_clr  in  1  sampled with accepted i_start; requests a post-counter clear.
- i_s_init  in  1  sample-init pulse; accepted only in IDLE.
- i_cur  in  288  18 x 16-bit unsigned currents; neuron k at [16k+:16]; latched on accepted i_start.
- i_inhbt  in  5  spike count of previous sweep; latched on accepted i_start.
- o_valid  out  1  spike-stream valid.
- o_spike  out  1  spike for o_neuron_idx; 0 when o_valid=0.
- o_neuron_idx  out  5  neuron index of current beat.
- o_s_init  out  1  trace/state clear for o_neuron_idx.
- o_cnt_clr  out  1  one-cycle post-counter clear.
- o_busy  out  1  FSM not IDLE.
- o_done  out  1  one-cycle pulse after a sweep or init pass ends.

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high. On reset, go to IDLE. All outputs reset to 0; all vmem[0..17] = 0; all refrac[0..17] = 0; idx = 0.
- All outputs are registered.
- FSM states: IDLE, SWEEP, INIT, DONE.
- IDLE:
  - If i_s_init=1 (wins over a same-cycle i_start, which is dropped): enter INIT with idx=0.
  - Else if i_start=1: latch i_cur and i_inhbt, enter SWEEP with idx=0. If i_cnt_clr=1, set o_cnt_clr=1 for exactly the next cycle, one cycle before the first o_valid beat.
- SWEEP:
  - One neuron k=idx per cycle; 18 consecutive cycles, no gaps.
  - The output beat (o_valid=1, o_neuron_idx=k, o_spike) appears the cycle after k is processed.
  - After k=17, go to DONE.
  - i_start and i_s_init are ignored while busy.
- Neuron update, in at least 19-bit signed arithmetic:
  - s = vmem[k] - (vmem[k]>>LEAK_SHIFT) + cur[k] - i_inhbt*INHBT_W.
  - Clamp s to [0, 65535].
  - If refrac[k] != 0: spike=0, vmem[k]=0, refrac[k]-=1.
  - Else if s >= THRESH: spike=1, vmem[k]=0, refrac[k]=REFRAC.
  - Else: spike=0, vmem[k]=s.
- INIT:
  - 18 cycles; each cycle, clear vmem[idx] and refrac[idx].
  - Next cycle, emit o_s_init=1, o_neuron_idx=idx, o_valid=0, o_spike=0.
  - After idx 17, go to DONE.
- DONE: o_done=1 for one cycle (the cycle after the last beat), o_busy=0, return to IDLE. A new i_start is accepted on the following cycle.
- o_busy is 1 from the cycle after acceptance through the last beat cycle.
- Reset mid-SWEEP/INIT: the next cycle has o_valid=o_s_init=0 and no o_done. Partially swept state is discarded (all cleared).

Test Plan:
- Reset, then i_start, i_cur=0, i_inhbt=0, i_cnt_clr=1 -> o_cnt_clr=1 one cycle, then 18 beats with idx 0..17 and o_spike=0, then o_done=1 for one cycle, o_busy=0.
- cur[3]=5000, others 0, 4 sweeps -> neuron 3 spikes on sweeps 1 and 4, silent on sweeps 2-3 (refractory). No other neuron spikes.
- cur[0]=1000 constant -> vmem[0] = 1000, 1938, 2817, 3641 after sweeps 1-4; spike on sweep 5; vmem[0]=0.
- i_inhbt=31, cur[1]=1000, vmem[1]=0 -> s=1000-1984 clamps to 0, no spike, vmem[1]=0. With cur[1]=0xFFFF and vmem[1]=60000: s clamps to 65535 and spikes.
- Charge neuron 0 to 3641, then i_s_init -> 18 cycles of o_s_init=1, idx 0..17, o_valid=0, then o_done. Next sweep with cur=0 gives no spikes and vmem[0]=0.
- Reset asserted at the idx 9 beat -> next cycle all outputs 0, o_busy=0. i_start pulsed mid-sweep (no reset) is ignored: exactly 18 beats, one o_done.
